button_encoder: RTL and testbench



---
 rtl/button_encoder.sv | 208 ++++++++++++++++++++
 tb/tb_button_encoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/button_encoder.sv
`default_nettype none
// ============================================================================
// Module   : button_encoder
// Purpose  : Debounces four colour buttons and a start button and encodes the
//            single held colour as KEY/KEY_VALID. Optional macro BTN_SYNC_EN
//            adds 2-flop input synchronizers.
// Revision : 1.0  initial release
// ============================================================================
module button_encoder #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [3:0] BTN,
   input  logic       START_BTN,
   output logic [1:0] KEY,
   output logic       KEY_VALID,
   output logic       START_GAME
);

   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_PRESS_DB   = 2'd1,
      ST_HELD       = 2'd2,
      ST_RELEASE_DB = 2'd3
   } state_t;

   logic [3:0] w_btn_s;
   logic       w_start_s;

`ifdef BTN_SYNC_EN
   logic [3:0] r_btn_meta;
   logic [3:0] r_btn_sync;
   logic       r_start_meta;
   logic       r_start_sync;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_btn_meta   <= 4'd0;
         r_btn_sync   <= 4'd0;
         r_start_meta <= 1'b0;
         r_start_sync <= 1'b0;
      end else begin
         r_btn_meta   <= BTN;
         r_btn_sync   <= r_btn_meta;
         r_start_meta <= START_BTN;
         r_start_sync <= r_start_meta;
      end
   end

   assign w_btn_s   = r_btn_sync;
   assign w_start_s = r_start_sync;
`else
   assign w_btn_s   = BTN;
   assign w_start_s = START_BTN;
`endif

   // ------------------------------------------------------------------
   // Key debounce FSM
   // ------------------------------------------------------------------
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [1:0]       r_cand;
   logic [1:0]       w_cand_nxt;
   logic [1:0]       r_key;
   logic [1:0]       w_key_nxt;
   logic             r_key_valid;
   logic             w_key_valid_nxt;

   logic             w_one_hot;
   logic [1:0]       w_btn_idx;
   logic [3:0]       w_cand_mask;
   logic             w_cand_bit;

   assign w_one_hot   = (w_btn_s != 4'd0) && ((w_btn_s & (w_btn_s - 4'd1)) == 4'd0);
   assign w_cand_mask = 4'b0001 << r_cand;
   assign w_cand_bit  = w_btn_s[r_cand];

   always_comb begin
      w_btn_idx = 2'd0;
      case (w_btn_s)
         4'b0010: w_btn_idx = 2'd1;
         4'b0100: w_btn_idx = 2'd2;
         4'b1000: w_btn_idx = 2'd3;
         default: w_btn_idx = 2'd0;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= ST_IDLE;
         r_cnt       <= c_CNT_ZERO;
         r_cand      <= 2'd0;
         r_key       <= 2'b11;
         r_key_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_cand      <= w_cand_nxt;
         r_key       <= w_key_nxt;
         r_key_valid <= w_key_valid_nxt;
      end
   end

   // Terminal compare precedes the increment so the counter never wraps.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_cand_nxt      = r_cand;
      w_key_nxt       = r_key;
      w_key_valid_nxt = r_key_valid;

      case (r_state)
         ST_IDLE: begin
            if (w_one_hot) begin
               w_cand_nxt  = w_btn_idx;
               w_cnt_nxt   = c_CNT_ZERO;
               w_state_nxt = ST_PRESS_DB;
            end
         end

         ST_PRESS_DB: begin
            if (w_btn_s == w_cand_mask) begin
               if (r_cnt == c_CNT_LAST) begin
                  w_key_nxt       = r_cand;
                  w_key_valid_nxt = 1'b1;
                  w_cnt_nxt       = c_CNT_ZERO;
                  w_state_nxt     = ST_HELD;
               end else begin
                  w_cnt_nxt = r_cnt + c_CNT_ONE;
               end
            end else begin
               w_cnt_nxt   = c_CNT_ZERO;
               w_state_nxt = ST_IDLE;
            end
         end

         ST_HELD: begin
            if (!w_cand_bit) begin
               w_cnt_nxt   = c_CNT_ZERO;
               w_state_nxt = ST_RELEASE_DB;
            end
         end

         ST_RELEASE_DB: begin
            if (w_cand_bit) begin
               w_cnt_nxt   = c_CNT_ZERO;
               w_state_nxt = ST_HELD;
            end else if (r_cnt == c_CNT_LAST) begin
               w_key_valid_nxt = 1'b0;
               w_cnt_nxt       = c_CNT_ZERO;
               w_state_nxt     = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
         end

         default: begin
            w_cnt_nxt   = c_CNT_ZERO;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Start channel: toggles once the input disagrees for the full window
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] r_scnt;
   logic [CNT_W-1:0] w_scnt_nxt;
   logic             r_start_game;
   logic             w_start_game_nxt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_scnt       <= c_CNT_ZERO;
         r_start_game <= 1'b0;
      end else begin
         r_scnt       <= w_scnt_nxt;
         r_start_game <= w_start_game_nxt;
      end
   end

   always_comb begin
      w_scnt_nxt       = r_scnt;
      w_start_game_nxt = r_start_game;
      if (w_start_s == r_start_game) begin
         w_scnt_nxt = c_CNT_ZERO;
      end else if (r_scnt == c_CNT_LAST) begin
         w_start_game_nxt = ~r_start_game;
         w_scnt_nxt       = c_CNT_ZERO;
      end else begin
         w_scnt_nxt = r_scnt + c_CNT_ONE;
      end
   end

   assign KEY        = r_key;
   assign KEY_VALID  = r_key_valid;
   assign START_GAME = r_start_game;

endmodule
`default_nettype wire

// File: tb/tb_button_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_encoder
// Purpose  : Directed scoreboard bench for button_encoder with DEBOUNCE_CYCLES=4.
// Revision : 1.0  initial release
// ============================================================================
module tb_button_encoder;

   localparam int D = 4;
`ifdef BTN_SYNC_EN
   localparam int L = 2;
`else
   localparam int L = 0;
`endif

   logic       CLK   = 1'b0;
   logic       RST_N = 1'b1;
   logic [3:0] BTN   = 4'd0;
   logic       START_BTN = 1'b0;
   logic [1:0] KEY;
   logic       KEY_VALID;
   logic       START_GAME;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      string      tag;
      logic [1:0] key;
      logic       kv;
      logic       sg;
   } exp_t;

   exp_t sb_q[$];

   button_encoder #(.DEBOUNCE_CYCLES(D)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .BTN        (BTN),
      .START_BTN  (START_BTN),
      .KEY        (KEY),
      .KEY_VALID  (KEY_VALID),
      .START_GAME (START_GAME)
   );

   always #5 CLK = ~CLK;

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [1:0] key, input logic kv, input logic sg);
      exp_t e;
      e.tag = tag;
      e.key = key;
      e.kv  = kv;
      e.sg  = sg;
      sb_q.push_back(e);
   endtask

   task automatic check_out();
      exp_t       e;
      logic [3:0] obs;
      logic [3:0] req;
      tests_run++;
      if (sb_q.size() == 0) begin
         tests_failed++;
         $error("FAIL scoreboard: observed empty queue, required one pending entry");
      end else begin
         e   = sb_q.pop_front();
         obs = {KEY, KEY_VALID, START_GAME};
         req = {e.key, e.kv, e.sg};
         assert (obs === req) else begin
            tests_failed++;
            $error("FAIL %s: observed KEY=%0d KEY_VALID=%b START_GAME=%b, required KEY=%0d KEY_VALID=%b START_GAME=%b",
                   e.tag, KEY, KEY_VALID, START_GAME, e.key, e.kv, e.sg);
         end
      end
   endtask

   initial begin
      // Reset
      #2 RST_N = 1'b0;
      expect_out("reset_hold", 2'd3, 1'b0, 1'b0);
      #2 check_out();
      tick(2);
      RST_N = 1'b1;
      expect_out("idle_10", 2'd3, 1'b0, 1'b0);
      tick(10); check_out();

      // Clean press of colour 2 and its release
      BTN = 4'b0100;
      expect_out("press_pre", 2'd3, 1'b0, 1'b0);
      tick(D + L); check_out();
      expect_out("press_acc", 2'd2, 1'b1, 1'b0);
      tick(1); check_out();
      BTN = 4'b0000;
      expect_out("rel_pre", 2'd2, 1'b1, 1'b0);
      tick(D + L); check_out();
      expect_out("rel_done", 2'd2, 1'b0, 1'b0);
      tick(1); check_out();

      // Bouncy press of colour 0
      BTN = 4'b0001; tick(2);
      BTN = 4'b0000; tick(1);
      BTN = 4'b0001;
      expect_out("bounce_pre", 2'd2, 1'b0, 1'b0);
      tick(D + L); check_out();
      expect_out("bounce_acc", 2'd0, 1'b1, 1'b0);
      tick(1); check_out();

      // One-cycle release glitch while held
      BTN = 4'b0000; tick(1);
      BTN = 4'b0001;
      expect_out("held_glitch", 2'd0, 1'b1, 1'b0);
      tick(D + 2 + L); check_out();
      BTN = 4'b0000;
      expect_out("bounce_rel", 2'd0, 1'b0, 1'b0);
      tick(D + 1 + L); check_out();

      // Multi-press is ignored; colour 3 accepted; extra button ignored
      BTN = 4'b0011;
      expect_out("multi_ign", 2'd0, 1'b0, 1'b0);
      tick(20); check_out();
      BTN = 4'b1000;
      expect_out("c3_pre", 2'd0, 1'b0, 1'b0);
      tick(D + L); check_out();
      expect_out("c3_acc", 2'd3, 1'b1, 1'b0);
      tick(1); check_out();
      BTN = 4'b1001;
      expect_out("c3_extra", 2'd3, 1'b1, 1'b0);
      tick(10); check_out();

      // Releasing colour 3 leaves colour 0 held alone: re-accepted via IDLE
      BTN = 4'b0001;
      expect_out("c3_rel", 2'd3, 1'b0, 1'b0);
      tick(D + 1 + L); check_out();
      expect_out("c0_after", 2'd0, 1'b1, 1'b0);
      tick(D + 1); check_out();
      BTN = 4'b0000;
      expect_out("c0_rel", 2'd0, 1'b0, 1'b0);
      tick(D + 1 + L); check_out();

      // Start channel
      START_BTN = 1'b1; tick(3);
      START_BTN = 1'b0;
      expect_out("start_short", 2'd0, 1'b0, 1'b0);
      tick(10); check_out();
      START_BTN = 1'b1;
      expect_out("start_pre", 2'd0, 1'b0, 1'b0);
      tick(D - 1 + L); check_out();
      expect_out("start_on", 2'd0, 1'b0, 1'b1);
      tick(1); check_out();
      START_BTN = 1'b0;
      expect_out("stop_pre", 2'd0, 1'b0, 1'b1);
      tick(D - 1 + L); check_out();
      expect_out("start_off", 2'd0, 1'b0, 1'b0);
      tick(1); check_out();

      // Asynchronous reset while a key is held, then re-press
      BTN = 4'b0100;
      expect_out("hold2", 2'd2, 1'b1, 1'b0);
      tick(D + 1 + L); check_out();
      #4 RST_N = 1'b0;
      expect_out("rst_async", 2'd3, 1'b0, 1'b0);
      #1 check_out();
      RST_N = 1'b1;
      expect_out("repress_pre", 2'd3, 1'b0, 1'b0);
      tick(D + L); check_out();
      expect_out("repress_acc", 2'd2, 1'b1, 1'b0);
      tick(1); check_out();

      if (sb_q.size() != 0) begin
         tests_run++;
         tests_failed++;
         $error("FAIL scoreboard_drain: observed %0d pending entries, required 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
